// File: rtl/gf_exp_sequencer.sv
// gf_exp_sequencer: computes base^exponent in GF(2^m) by right-to-left
// square-and-multiply, driving an external GF multiplier ALU one
// operation at a time. Field width and reduction polynomial are whatever
// the ALU is already configured for.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start; operands latched on acceptance
// S_MUL_REQ  | issue acc*sq to the ALU (one-cycle enable)
// S_MUL_WAIT | wait for product, then acc := product and shift exponent
// S_SQR_REQ  | issue sq*sq to the ALU (one-cycle enable)
// S_SQR_WAIT | wait for square, then sq := square and pick next bit
// S_FINISH   | publish acc as result, pulse done, drop busy
module gf_exp_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [31:0]           exponent,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  alu_op_enable,
    output logic                  alu_red_funct,
    output logic                  alu_carry_option,
    output logic [DATA_WIDTH-1:0] alu_in_a,
    output logic [DATA_WIDTH-1:0] alu_in_b,
    input  logic                  alu_op_finish,
    input  logic [DATA_WIDTH-1:0] alu_out_poly
);

    // Down-counter reload: terminal count 0 is reached after TIMEOUT wait cycles.
    localparam int                TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] GF_ONE = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_SQR_REQ,
        S_SQR_WAIT,
        S_FINISH
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] sq_q;
    logic [31:0]           e_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  alu_op_enable_q;
    logic                  alu_red_funct_q;
    logic                  alu_carry_option_q;
    logic [DATA_WIDTH-1:0] alu_in_a_q;
    logic [DATA_WIDTH-1:0] alu_in_b_q;
    logic [31:0]           e_shr;

    assign e_shr = {1'b0, e_q[31:1]};

    // Sequencer FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q            <= S_IDLE;
            acc_q              <= '0;
            sq_q               <= '0;
            e_q                <= '0;
            tmo_q              <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            result_q           <= '0;
            alu_op_enable_q    <= 1'b0;
            alu_red_funct_q    <= 1'b0;
            alu_carry_option_q <= 1'b0;
            alu_in_a_q         <= '0;
            alu_in_b_q         <= '0;
        end else begin
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            alu_op_enable_q    <= 1'b0;
            alu_red_funct_q    <= 1'b0;
            alu_carry_option_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q  <= GF_ONE;
                        sq_q   <= base;
                        busy_q <= 1'b1;
                        tmo_q  <= '0;
                        if (exponent == 32'd0) begin
                            e_q     <= '0;
                            state_q <= S_FINISH;
                        end else if (exponent[0]) begin
                            e_q     <= exponent;
                            state_q <= S_MUL_REQ;
                        end else begin
                            // Low bit is zero: no multiply, consume it and square first.
                            e_q     <= {1'b0, exponent[31:1]};
                            state_q <= S_SQR_REQ;
                        end
                    end
                end
                S_MUL_REQ: begin
                    alu_op_enable_q <= 1'b1;
                    alu_red_funct_q <= 1'b1;
                    alu_in_a_q      <= acc_q;
                    alu_in_b_q      <= sq_q;
                    tmo_q           <= TMO_LOAD;
                    state_q         <= S_MUL_WAIT;
                end
                S_SQR_REQ: begin
                    alu_op_enable_q <= 1'b1;
                    alu_red_funct_q <= 1'b1;
                    alu_in_a_q      <= sq_q;
                    alu_in_b_q      <= sq_q;
                    tmo_q           <= TMO_LOAD;
                    state_q         <= S_SQR_WAIT;
                end
                S_MUL_WAIT, S_SQR_WAIT: begin
                    if (alu_op_finish) begin
                        if (state_q == S_MUL_WAIT) begin
                            acc_q   <= alu_out_poly;
                            e_q     <= e_shr;
                            state_q <= (e_shr != 32'd0) ? S_SQR_REQ : S_FINISH;
                        end else begin
                            sq_q <= alu_out_poly;
                            // e_q is nonzero here, so a zero low bit implies more bits remain.
                            if (e_q[0]) begin
                                state_q <= S_MUL_REQ;
                            end else begin
                                e_q     <= e_shr;
                                state_q <= S_SQR_REQ;
                            end
                        end
                    end else if (tmo_q == '0) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                S_FINISH: begin
                    result_q <= acc_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign result           = result_q;
    assign alu_op_enable    = alu_op_enable_q;
    assign alu_red_funct    = alu_red_funct_q;
    assign alu_carry_option = alu_carry_option_q;
    assign alu_in_a         = alu_in_a_q;
    assign alu_in_b         = alu_in_b_q;

endmodule

// File: tb/tb_gf_exp_sequencer.sv
// Bench for gf_exp_sequencer with a GF(2^8)/0x11B multiplier ALU model.
module tb_gf_exp_sequencer;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [DW-1:0] base;
    logic [31:0]   exponent;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] result;
    logic          alu_op_enable;
    logic          alu_red_funct;
    logic          alu_carry_option;
    logic [DW-1:0] alu_in_a;
    logic [DW-1:0] alu_in_b;
    logic          alu_op_finish;
    logic [DW-1:0] alu_out_poly;

    gf_exp_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .start            (start),
        .base             (base),
        .exponent         (exponent),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .result           (result),
        .alu_op_enable    (alu_op_enable),
        .alu_red_funct    (alu_red_funct),
        .alu_carry_option (alu_carry_option),
        .alu_in_a         (alu_in_a),
        .alu_in_b         (alu_in_b),
        .alu_op_finish    (alu_op_finish),
        .alu_out_poly     (alu_out_poly)
    );

    int total = 0;
    int bad   = 0;

    // shared state between driver and monitor
    int          alu_lat;
    bit          alu_mute;
    int          alu_cnt;
    logic [7:0]  alu_prod;
    logic [7:0]  exp_result;
    int          exp_ops;
    int          ops_base;
    int          ops_total  = 0;
    int          done_total = 0;
    int          err_total  = 0;
    bit          done_armed = 0;
    bit          err_armed  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Plain repeated multiplication, independent of square-and-multiply.
    function automatic logic [7:0] gf_pow(input logic [7:0] b, input logic [31:0] e);
        logic [7:0] r;
        r = 8'h01;
        for (longint i = 0; i < longint'(e); i++) r = gf_mul(r, b);
        return r;
    endfunction

    function automatic int op_count(input logic [31:0] e);
        int bl;
        bl = 0;
        for (int i = 0; i < 32; i++) if (e[i]) bl = i + 1;
        return (e == 0) ? 0 : ($countones(e) + bl - 1);
    endfunction

    // ALU model: finish pulse alu_lat cycles after a seen enable; garbage otherwise.
    initial begin
        alu_op_finish = 1'b0;
        alu_out_poly  = '0;
        alu_cnt       = 0;
        forever begin
            @(negedge clk);
            #1;
            alu_op_finish = 1'b0;
            alu_out_poly  = 8'($urandom);
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_op_finish = 1'b1;
                    alu_out_poly  = alu_prod;
                end
            end
            if (alu_op_enable && !alu_mute) begin
                alu_prod = gf_mul(alu_in_a, alu_in_b);
                alu_cnt  = alu_lat;
            end
        end
    end

    // Per-cycle monitor comparing DUT outputs to the model's expectations.
    initial begin : monitor
        int         cyc;
        int         en_cyc;
        bit         hold;
        bit         prev_en;
        bit         prev_done;
        logic [7:0] ha, hb, res_hold;
        cyc = 0; en_cyc = 0; hold = 0; prev_en = 0; prev_done = 0;
        ha = 0; hb = 0; res_hold = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                hold = 0; prev_en = 0; prev_done = 0; res_hold = 0;
                done_armed = 0; err_armed = 0;
                continue;
            end
            chk("carry_option", alu_carry_option, 1'b0);
            chk("red_funct", alu_red_funct, alu_op_enable);
            chk("enable_one_cycle", alu_op_enable && prev_en, 1'b0);
            chk("done_one_cycle", done && prev_done, 1'b0);
            chk("done_error_excl", done && error, 1'b0);
            if (hold && !alu_op_enable) begin
                chk("alu_in_a_stable", alu_in_a, ha);
                chk("alu_in_b_stable", alu_in_b, hb);
            end
            if (alu_op_enable) begin
                ops_total++;
                en_cyc = cyc;
                hold   = 1;
                ha     = alu_in_a;
                hb     = alu_in_b;
            end
            if (alu_op_finish) hold = 0;
            if (done) begin
                done_total++;
                chk("done_expected", done_armed, 1'b1);
                chk("result", result, exp_result);
                chk("op_count", ops_total - ops_base, exp_ops);
                chk("busy_at_done", busy, 1'b0);
                done_armed = 0;
                res_hold   = result;
            end else begin
                chk("result_held", result, res_hold);
            end
            if (error) begin
                err_total++;
                chk("error_expected", err_armed, 1'b1);
                chk("error_wait_cycles", cyc - en_cyc, TMO);
                chk("busy_at_error", busy, 1'b0);
                err_armed = 0;
                hold      = 0;
            end
            prev_en   = alu_op_enable;
            prev_done = done;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_enable"}, alu_op_enable, 0);
        chk({tag, "_red"}, alu_red_funct, 0);
        chk({tag, "_carry"}, alu_carry_option, 0);
        chk({tag, "_in_a"}, alu_in_a, 0);
        chk({tag, "_in_b"}, alu_in_b, 0);
    endtask

    task automatic run_op(input logic [7:0] b, input logic [31:0] e, input int lat,
                          input bit mute, input bit want_err, input int stray_at,
                          input int want_lat);
        int n, d0, e0, o0;
        alu_lat    = lat;
        alu_mute   = mute;
        exp_result = gf_pow(b, e);
        exp_ops    = want_err ? 1 : op_count(e);
        d0 = done_total; e0 = err_total;
        @(negedge clk);
        #1;
        o0       = ops_total;
        ops_base = ops_total;
        if (want_err) err_armed = 1; else done_armed = 1;
        base     = b;
        exponent = e;
        start    = 1'b1;
        @(negedge clk);
        n = 1;
        chk("busy_after_start", busy, 1'b1);
        #1;
        start    = 1'b0;
        base     = 8'($urandom);
        exponent = $urandom;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
            if (done || error) break;
            #1;
            start = (n == stray_at);
            if (start) begin
                base     = 8'($urandom);
                exponent = $urandom;
            end
        end
        #1;
        start = 1'b0;
        chk("completion_in_budget", n < 3000, 1'b1);
        if (want_lat > 0) chk("start_to_done_latency", n, want_lat);
        chk("done_pulses", done_total - d0, want_err ? 0 : 1);
        chk("error_pulses", err_total - e0, want_err ? 1 : 0);
        chk("ops_issued", ops_total - o0, exp_ops);
        chk("busy_after_end", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, d0, e0, o_mid;
        logic [7:0] r_before;
        resetn = 1'b0; start = 1'b0; base = '0; exponent = '0;
        alu_lat = 3; alu_mute = 0;
        exp_result = 0; exp_ops = 0; ops_base = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #1;
        resetn = 1'b1;

        // hand-computed anchors for the model
        chk("pin_mul_57_83", gf_mul(8'h57, 8'h83), 8'hC1);
        chk("pin_mul_53_CA", gf_mul(8'h53, 8'hCA), 8'h01);
        chk("pin_pow_02_8", gf_pow(8'h02, 8), 8'h1B);
        chk("pin_pow_53_254", gf_pow(8'h53, 254), 8'hCA);
        chk("pin_ops_8", op_count(8), 4);
        chk("pin_ops_254", op_count(254), 14);

        run_op(8'h02, 32'd8,    3, 0, 0, -1, 0);
        chk("res_02_8", result, 8'h1B);
        run_op(8'h53, 32'd254,  3, 0, 0, -1, 0);
        chk("res_53_254", result, 8'hCA);
        run_op(8'h57, 32'd0,    3, 0, 0, -1, 2);
        chk("res_57_0", result, 8'h01);
        run_op(8'h03, 32'd5,    1, 0, 0, -1, 0);
        run_op(8'h1F, 32'd1,    1, 0, 0, -1, 0);
        chk("res_1F_1", result, 8'h1F);
        run_op(8'h35, 32'd1000, 2, 0, 0, -1, 0);
        // a second start while busy must be ignored
        run_op(8'h53, 32'd254,  3, 0, 0, 20, 0);
        chk("res_stray_start", result, 8'hCA);

        // ALU never answers: timeout error, result untouched
        r_before = result;
        run_op(8'h05, 32'd3,    3, 1, 1, -1, 0);
        chk("res_after_timeout", result, r_before);
        alu_mute = 0;

        // reset while waiting on a multiply, with a stale finish arriving later
        alu_lat = 3;
        d0 = done_total; e0 = err_total;
        @(negedge clk);
        #1;
        base = 8'h02; exponent = 32'd3; start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (alu_op_enable) break;
        end
        chk("reset_test_enable_seen", alu_op_enable, 1'b1);
        #1;
        o_mid  = ops_total;
        resetn = 1'b0;
        @(negedge clk);
        chk_all_zero("midop_reset");
        #1;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("stale_finish_busy", busy, 1'b0);
        #1;
        chk("stale_finish_no_done", done_total - d0, 0);
        chk("stale_finish_no_error", err_total - e0, 0);
        chk("stale_finish_no_ops", ops_total, o_mid);

        run_op(8'h02, 32'd8, 3, 0, 0, -1, 0);
        chk("res_after_reset", result, 8'h1B);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_exp_sequencer.md
GF_EXP_SEQUENCER -- requirements
Module: gf_exp_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, field-element width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles to wait for alu_op_finish per ALU operation.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin base^exponent.
REQ-006 SHALL have port base  input  DATA_WIDTH  operand base, sampled on accepted start.
REQ-007 SHALL have port exponent  input  32  unsigned exponent, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done/error.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port error  output  1  one-cycle pulse on ALU timeout.
REQ-011 SHALL have port result  output  DATA_WIDTH  final product, held until next accepted start.
REQ-012 SHALL have port alu_op_enable  output  1  one-cycle ALU operation request.
REQ-013 SHALL have port alu_red_funct  output  1  driven 1 with every alu_op_enable (reduced product).
REQ-014 SHALL have port alu_carry_option  output  1  driven 0 with every alu_op_enable (carry-less).
REQ-015 SHALL have ports alu_in_a, alu_in_b  output  DATA_WIDTH  ALU operands, stable from alu_op_enable until alu_op_finish.
REQ-016 SHALL have port alu_op_finish  input  1  one-cycle ALU completion pulse.
REQ-017 SHALL have port alu_out_poly  input  DATA_WIDTH  reduced product, valid while alu_op_finish high.

Function
REQ-018 SHALL compute base^exponent in GF(2^m) using the ALU's pre-configured width and reduction polynomial; no configuration is driven by this block.
REQ-019 SHALL use right-to-left square-and-multiply: acc=1, sq=base, e=exponent; per iteration: if e[0] then acc=acc*sq; e=e>>1; if e!=0 then sq=sq*sq; loop while e!=0.
REQ-020 SHALL implement FSM states IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, FINISH.
REQ-021 SHALL, in IDLE with start=1, latch operands and go to FINISH if exponent==0, else MUL_REQ if exponent[0]==1, else SQR_REQ.
REQ-022 SHALL, in MUL_REQ/SQR_REQ, pulse alu_op_enable for exactly one cycle with alu_in_a/alu_in_b = acc/sq or sq/sq, then enter the matching WAIT state.
REQ-023 SHALL, in MUL_WAIT on alu_op_finish, load acc from alu_out_poly, shift e, then go to SQR_REQ if shifted e!=0, else FINISH.
REQ-024 SHALL, in SQR_WAIT on alu_op_finish, load sq from alu_out_poly, then go to MUL_REQ if e[0]==1, else shift e and repeat decision (SQR_REQ if e!=0).
REQ-025 SHALL issue exactly popcount(exponent) multiplies plus (bit_length(exponent)-1) squarings; no ALU operation for exponent 0.
REQ-026 SHALL, in FINISH, drive result=acc, pulse done one cycle, deassert busy in the same cycle, return to IDLE.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL count cycles in each WAIT state; on reaching TIMEOUT without alu_op_finish, pulse error, leave result unchanged, deassert busy, return to IDLE.
REQ-029 SHALL ignore alu_op_finish in any state other than MUL_WAIT/SQR_WAIT.
REQ-030 SHALL accept alu_op_finish arriving the cycle after alu_op_enable (minimum latency 1).

Reset
REQ-031 SHALL, when resetn=0 at a clock edge, enter IDLE and clear busy, done, error, alu_op_enable, alu_red_funct, alu_carry_option, alu_in_a, alu_in_b, result, timeout counter to 0.
REQ-032 SHALL, on reset mid-operation, abandon the computation with no done/error pulse, and ignore a subsequent stale alu_op_finish.

Verification (ALU model: GF(2^8), polynomial 0x11B, latency 3)
REQ-033 SHALL verify base=0x02, exponent=8 -> result=0x1B, done once, 4 alu_op_enable pulses.
REQ-034 SHALL verify base=0x53, exponent=254 -> result=0xCA (inverse), 14 ALU operations.
REQ-035 SHALL verify base=0x57, exponent=0 -> result=0x01, done 2 cycles after start, zero alu_op_enable.
REQ-036 SHALL verify ALU model never asserting finish, TIMEOUT=16 -> error pulse after 16 wait cycles, busy low, result unchanged.
REQ-037 SHALL verify start pulse during busy and resetn=0 during MUL_WAIT -> second start ignored; after reset all outputs 0, late alu_op_finish produces no done.
